// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-write path: frame layout, register map and controller states.
package spi_reg_pkg;

    localparam int FRAME_W  = 16;
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int CNT_W    = 8;

    localparam logic [6:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] REG_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP,
        DONE
    } spi_ctrl_state_t;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic       rw,
        input logic [6:0] addr,
        input logic [7:0] wdata
    );
        return {rw, addr, wdata};
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Phase timer: counts CLK_DIV cycles per phase while running and strobes phase_end on the last one.
module spi_phase_timer
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic phase_end
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Held at zero while stopped so the first phase after a start is a full H cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign phase_end = run && (cnt == LAST);

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 initiator: serialises one {rw, addr, wdata} frame per accepted request, MSB first.
module spi_reg_writer
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       ncs,
    output logic       copi
);

    spi_ctrl_state_t    state;
    logic [FRAME_W-1:0] shreg;
    logic [3:0]         bit_cnt;
    logic               run;
    logic               phase_end;

    assign run = (state == SHIFT) || (state == HOLD) || (state == GAP);

    spi_phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .phase_end(phase_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            ncs     <= 1'b1;
            copi    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= SHIFT;
                        shreg   <= pack_frame(rw, addr, wdata);
                        bit_cnt <= 4'd15;
                        busy    <= 1'b1;
                        ncs     <= 1'b0;
                        sclk    <= 1'b0;
                        copi    <= rw;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (phase_end) begin
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            // Last bit stays on copi through HOLD for the peripheral's hold time.
                            if (bit_cnt == 4'd0) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt - 4'd1;
                                shreg   <= {shreg[FRAME_W-2:0], shreg[FRAME_W-1]};
                                copi    <= shreg[FRAME_W-2];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        state <= GAP;
                        ncs   <= 1'b1;
                        copi  <= 1'b0;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Bench for spi_reg_writer at CLK_DIV = 4, 1 and 255: frames are pushed to per-instance queues on drive
// and compared against the bits captured at sclk rises when ncs returns high.
module tb_spi_reg_writer;
    import spi_reg_pkg::*;

    localparam int N = 3;
    localparam int HV [N] = '{4, 1, 255};

    logic       clk = 1'b0;
    logic       rst_n [N];
    logic       start [N];
    logic       rw    [N];
    logic [6:0] addr  [N];
    logic [7:0] wdata [N];
    logic       busy  [N];
    logic       done  [N];
    logic       sclk  [N];
    logic       ncs   [N];
    logic       copi  [N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drive_cyc = 0;

    logic [15:0] exp_q [N][$];
    logic [15:0] mon_exp;

    logic        pn [N];
    logic        ps [N];
    logic        pc [N];
    logic        act [N];
    logic [15:0] cap [N];
    int nbits [N], fall_c [N], prev_fall [N], rise_c [N], gap [N], viol [N], falls [N], dones [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_reg_writer #(.CLK_DIV(4)) u_h4 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .rw(rw[0]), .addr(addr[0]), .wdata(wdata[0]),
        .busy(busy[0]), .done(done[0]), .sclk(sclk[0]), .ncs(ncs[0]), .copi(copi[0])
    );
    spi_reg_writer #(.CLK_DIV(1)) u_h1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .rw(rw[1]), .addr(addr[1]), .wdata(wdata[1]),
        .busy(busy[1]), .done(done[1]), .sclk(sclk[1]), .ncs(ncs[1]), .copi(copi[1])
    );
    spi_reg_writer #(.CLK_DIV(255)) u_h255 (
        .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .rw(rw[2]), .addr(addr[2]), .wdata(wdata[2]),
        .busy(busy[2]), .done(done[2]), .sclk(sclk[2]), .ncs(ncs[2]), .copi(copi[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: reconstructs each frame from the SPI pins and scores it against the queue.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n[i]) begin
                act[i] = 1'b0;
                pn[i]  = 1'b1;
                ps[i]  = 1'b0;
                pc[i]  = 1'b0;
            end else begin
                if (pn[i] && !ncs[i]) begin
                    act[i]       = 1'b1;
                    nbits[i]     = 0;
                    cap[i]       = '0;
                    viol[i]      = 0;
                    gap[i]       = cyc - rise_c[i];
                    prev_fall[i] = fall_c[i];
                    fall_c[i]    = cyc;
                    falls[i]++;
                end
                if (act[i] && sclk[i] && copi[i] !== pc[i]) viol[i]++;
                if (act[i] && !ps[i] && sclk[i]) begin
                    if (nbits[i] == 0)
                        check($sformatf("h%0d_first_rise", HV[i]), 32'(cyc - fall_c[i]), 32'(HV[i]));
                    cap[i] = {cap[i][14:0], copi[i]};
                    nbits[i]++;
                end
                if (act[i] && !pn[i] && ncs[i]) begin
                    check($sformatf("h%0d_nbits", HV[i]), 32'(nbits[i]), 32'd16);
                    check($sformatf("h%0d_ncs_low", HV[i]), 32'(cyc - fall_c[i]), 32'(33 * HV[i]));
                    check($sformatf("h%0d_copi_stable", HV[i]), 32'(viol[i]), 32'd0);
                    check($sformatf("h%0d_copi_idle", HV[i]), 32'(copi[i]), 32'd0);
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("h%0d_unexpected_frame", HV[i]), 32'd1, 32'd0);
                    end else begin
                        mon_exp = exp_q[i].pop_front();
                        check($sformatf("h%0d_frame", HV[i]), 32'(cap[i]), 32'(mon_exp));
                    end
                    rise_c[i] = cyc;
                    act[i]    = 1'b0;
                end
                if (done[i]) begin
                    dones[i]++;
                    check($sformatf("h%0d_done_lat", HV[i]), 32'(cyc - fall_c[i]), 32'(34 * HV[i]));
                    check($sformatf("h%0d_done_busy", HV[i]), 32'(busy[i]), 32'd0);
                end
                pn[i] = ncs[i];
                ps[i] = sclk[i];
                pc[i] = copi[i];
            end
        end
    end

    task automatic send(input int i, input logic r, input logic [6:0] a, input logic [7:0] d);
        int k = 0;
        while (busy[i] && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("send_wait", 32'(k < 20000), 32'd1);
        start[i]  = 1'b1;
        rw[i]     = r;
        addr[i]   = a;
        wdata[i]  = d;
        drive_cyc = cyc;
        exp_q[i].push_back(pack_frame(r, a, d));
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int limit);
        int k = 0;
        logic seen = 1'b0;
        while (!seen && k < limit) begin
            @(negedge clk);
            seen = done[i];
            k++;
        end
        check($sformatf("h%0d_done_timeout", HV[i]), 32'(seen), 32'd1);
    endtask

    task automatic pulse_other(input int i);
        start[i] = 1'b1;
        rw[i]    = 1'b0;
        addr[i]  = 7'h55;
        wdata[i] = 8'h3C;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    initial begin
        int f0, d0;
        for (int i = 0; i < N; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
            pn[i] = 1'b1; ps[i] = 1'b0; pc[i] = 1'b0; act[i] = 1'b0; cap[i] = '0;
            nbits[i] = 0; fall_c[i] = 0; prev_fall[i] = 0; rise_c[i] = 0; gap[i] = 0;
            viol[i] = 0; falls[i] = 0; dones[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("h%0d_rst_busy", HV[i]), 32'(busy[i]), 32'd0);
            check($sformatf("h%0d_rst_done", HV[i]), 32'(done[i]), 32'd0);
            check($sformatf("h%0d_rst_sclk", HV[i]), 32'(sclk[i]), 32'd0);
            check($sformatf("h%0d_rst_ncs", HV[i]), 32'(ncs[i]), 32'd1);
            check($sformatf("h%0d_rst_copi", HV[i]), 32'(copi[i]), 32'd0);
            rst_n[i] = 1'b1;
        end
        @(negedge clk);

        // Single write: 1000_0100_1000_0000
        send(0, 1'b1, REG_PWM_DUTY, 8'h80);
        check("single_busy", 32'(busy[0]), 32'd1);
        check("single_ncs", 32'(ncs[0]), 32'd0);
        check("single_copi_b15", 32'(copi[0]), 32'd1);
        wait_done(0, 400);
        check("single_done_at", 32'(cyc - drive_cyc), 32'd137);
        repeat (3) @(negedge clk);

        // Requests while busy are dropped
        f0 = falls[0];
        d0 = dones[0];
        send(0, 1'b1, REG_EN_PWM_15_8, 8'hA5);
        repeat (2) @(negedge clk);
        pulse_other(0);
        repeat (56) @(negedge clk);
        pulse_other(0);
        repeat (69) @(negedge clk);
        pulse_other(0);
        wait_done(0, 400);
        repeat (40) @(negedge clk);
        check("busy_one_frame", 32'(falls[0] - f0), 32'd1);
        check("busy_one_done", 32'(dones[0] - d0), 32'd1);

        // Back-to-back with start held high
        start[0] = 1'b1; rw[0] = 1'b1; addr[0] = REG_EN_OUT_7_0; wdata[0] = 8'h01;
        exp_q[0].push_back(pack_frame(1'b1, REG_EN_OUT_7_0, 8'h01));
        @(negedge clk);
        check("b2b_busy1", 32'(busy[0]), 32'd1);
        addr[0] = REG_EN_PWM_7_0;
        exp_q[0].push_back(pack_frame(1'b1, REG_EN_PWM_7_0, 8'h01));
        wait_done(0, 400);
        @(negedge clk);
        start[0] = 1'b0;
        check("b2b_busy2", 32'(busy[0]), 32'd1);
        wait_done(0, 400);
        check("b2b_fall_to_fall", 32'(fall_c[0] - prev_fall[0]), 32'd137);
        check("b2b_ncs_high", 32'(gap[0]), 32'd5);
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a frame
        send(0, 1'b1, REG_EN_OUT_15_8, 8'hC3);
        repeat (38) @(negedge clk);
        #1 rst_n[0] = 1'b0;
        #1;
        check("arst_ncs", 32'(ncs[0]), 32'd1);
        check("arst_sclk", 32'(sclk[0]), 32'd0);
        check("arst_copi", 32'(copi[0]), 32'd0);
        check("arst_busy", 32'(busy[0]), 32'd0);
        exp_q[0].delete();
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_no_resume", 32'(ncs[0]), 32'd1);
        send(0, 1'b0, 7'h2A, 8'h5A);
        wait_done(0, 400);
        check("arst_done_at", 32'(cyc - drive_cyc), 32'd137);

        // All-ones frames at the divider extremes
        send(1, 1'b1, 7'h7F, 8'hFF);
        wait_done(1, 100);
        check("h1_done_at", 32'(cyc - drive_cyc), 32'd35);
        send(2, 1'b1, 7'h7F, 8'hFF);
        wait_done(2, 9000);
        check("h255_done_at", 32'(cyc - drive_cyc), 32'd8671);

        repeat (5) @(negedge clk);
        for (int i = 0; i < N; i++)
            check($sformatf("h%0d_queue_empty", HV[i]), 32'(exp_q[i].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
